// File: rtl/snake_pkg.sv
// Shared direction/state encodings for the snake engine and its helpers.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_RUNNING = 2'b00,
    ST_DIE     = 2'b01,
    ST_INITIAL = 2'b10
  } state_e;

  function automatic dir_e opposite_dir(input dir_e d);
    opposite_dir = DIR_LEFT;
    case (d)
      DIR_UP:    opposite_dir = DIR_DOWN;
      DIR_DOWN:  opposite_dir = DIR_UP;
      DIR_RIGHT: opposite_dir = DIR_LEFT;
      DIR_LEFT:  opposite_dir = DIR_RIGHT;
      default:   opposite_dir = DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head cell plus wall/wrap decision for one move.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int GRID_W = 32,
  parameter int GRID_H = 24,
  parameter int WRAP   = 0,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H)
) (
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  input  dir_e          i_dir,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_out
);

  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

  // Edges are compared against the true grid bounds so non-power-of-2 grids wrap correctly.
  always_comb begin
    o_x   = i_x;
    o_y   = i_y;
    o_out = 1'b0;
    case (i_dir)
      DIR_UP: begin
        if (i_y == '0) begin
          o_y   = Y_MAX;
          o_out = (WRAP == 0);
        end else begin
          o_y = i_y - 1'b1;
        end
      end
      DIR_DOWN: begin
        if (i_y == Y_MAX) begin
          o_y   = '0;
          o_out = (WRAP == 0);
        end else begin
          o_y = i_y + 1'b1;
        end
      end
      DIR_RIGHT: begin
        if (i_x == X_MAX) begin
          o_x   = '0;
          o_out = (WRAP == 0);
        end else begin
          o_x = i_x + 1'b1;
        end
      end
      default: begin
        if (i_x == '0) begin
          o_x   = X_MAX;
          o_out = (WRAP == 0);
        end else begin
          o_x = i_x - 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/snake_engine.sv
// Snake body, direction handling, growth and wall/self collision with a 3-state game FSM.
module snake_engine
  import snake_pkg::*;
#(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3,
  parameter int WRAP     = 0,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  step,
  input  logic                  pause,
  input  logic [1:0]            dir_req,
  input  logic [XW-1:0]         food_x,
  input  logic [YW-1:0]         food_y,
  output logic [1:0]            game_state,
  output logic [1:0]            cur_dir,
  output logic [LW-1:0]         snake_len,
  output logic [MAX_LEN*XW-1:0] snake_x_flat,
  output logic [MAX_LEN*YW-1:0] snake_y_flat,
  output logic                  get_food,
  output logic                  hit_boundary,
  output logic                  hit_self
);

  state_e        r_state, w_state_nxt;
  dir_e          r_cur_dir, r_pend_dir;
  logic [XW-1:0] r_seg_x [MAX_LEN];
  logic [YW-1:0] r_seg_y [MAX_LEN];
  logic [LW-1:0] r_len;
  logic          r_get_food, r_hit_boundary, r_hit_self;

  logic [XW-1:0] w_nx;
  logic [YW-1:0] w_ny;
  logic [LW-1:0] w_chk_len;
  logic          w_out, w_grow, w_self, w_move, w_die, w_advance;

  function automatic logic [XW-1:0] init_x(input int unsigned i);
    init_x = (i < INIT_LEN) ? XW'(GRID_W / 2 - int'(i)) : '0;
  endfunction

  function automatic logic [YW-1:0] init_y(input int unsigned i);
    init_y = (i < INIT_LEN) ? YW'(GRID_H / 2) : '0;
  endfunction

  snake_next_head #(
    .GRID_W(GRID_W),
    .GRID_H(GRID_H),
    .WRAP  (WRAP)
  ) u_next_head (
    .i_x  (r_seg_x[0]),
    .i_y  (r_seg_y[0]),
    .i_dir(r_pend_dir),
    .o_x  (w_nx),
    .o_y  (w_ny),
    .o_out(w_out)
  );

  assign w_move    = (r_state == ST_RUNNING) && step && !pause && !start;
  assign w_grow    = (w_nx == food_x) && (w_ny == food_y);
  // The tail cell is vacated by the move unless the snake grows.
  assign w_chk_len = w_grow ? r_len : r_len - 1'b1;
  assign w_die     = w_move && (w_out || w_self);
  assign w_advance = w_move && !w_out && !w_self;

  always_comb begin
    w_self = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < w_chk_len) && (r_seg_x[i] == w_nx) && (r_seg_y[i] == w_ny)) begin
        w_self = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_dir <= DIR_RIGHT;
    end else if (start) begin
      r_pend_dir <= DIR_RIGHT;
    end else if (dir_e'(dir_req) != opposite_dir(r_cur_dir)) begin
      r_pend_dir <= dir_e'(dir_req);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= init_x(i);
        r_seg_y[i] <= init_y(i);
      end
      r_len          <= LW'(INIT_LEN);
      r_cur_dir      <= DIR_RIGHT;
      r_get_food     <= 1'b0;
      r_hit_boundary <= 1'b0;
      r_hit_self     <= 1'b0;
    end else if (start) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= init_x(i);
        r_seg_y[i] <= init_y(i);
      end
      r_len          <= LW'(INIT_LEN);
      r_cur_dir      <= DIR_RIGHT;
      r_get_food     <= 1'b0;
      r_hit_boundary <= 1'b0;
      r_hit_self     <= 1'b0;
    end else if (w_advance) begin
      for (int unsigned i = 1; i < MAX_LEN; i++) begin
        r_seg_x[i] <= r_seg_x[i-1];
        r_seg_y[i] <= r_seg_y[i-1];
      end
      r_seg_x[0] <= w_nx;
      r_seg_y[0] <= w_ny;
      r_cur_dir  <= r_pend_dir;
      r_get_food <= w_grow;
      if (w_grow && (r_len != LW'(MAX_LEN))) begin
        r_len <= r_len + 1'b1;
      end
    end else begin
      r_get_food <= 1'b0;
      if (w_die) begin
        r_hit_boundary <= w_out;
        r_hit_self     <= !w_out;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_INITIAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INITIAL: if (start) w_state_nxt = ST_RUNNING;
      ST_RUNNING: begin
        if (start)      w_state_nxt = ST_RUNNING;
        else if (w_die) w_state_nxt = ST_DIE;
      end
      ST_DIE:     if (start) w_state_nxt = ST_RUNNING;
      default:    w_state_nxt = ST_INITIAL;
    endcase
  end

  always_comb begin
    game_state   = r_state;
    cur_dir      = r_cur_dir;
    snake_len    = r_len;
    get_food     = r_get_food;
    hit_boundary = r_hit_boundary;
    hit_self     = r_hit_self;
    snake_x_flat = '0;
    snake_y_flat = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      snake_x_flat[i*XW +: XW] = r_seg_x[i];
      snake_y_flat[i*YW +: YW] = r_seg_y[i];
    end
  end

endmodule

// File: doc/snake_engine.md
# snake_engine

Parametrised successor to the snake game's movement/collision logic: one block holds the snake body, applies direction requests on each move strobe, and detects growth, wall hits and self hits. Grid size, maximum length, initial length and wall/wrap mode are parameters. It sits between the direction/FSM logic and the VGA renderer, replacing the fixed 32×24, 64-segment, wall-only behaviour.

## Interface
- GRID_W, 32, grid columns (≥ 4)
- GRID_H, 24, grid rows (≥ 4)
- MAX_LEN, 64, maximum segments (≥ INIT_LEN)
- INIT_LEN, 3, length after start (2..GRID_W/2)
- WRAP, 0, 0 = walls kill, 1 = toroidal wrap-around
- XW / YW, derived, $clog2(GRID_W) / $clog2(GRID_H); LW = $clog2(MAX_LEN+1)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  (re)initialise snake and enter RUNNING
- step  in  1  one-cycle move strobe from the speed divider
- pause  in  1  step ignored while high
- dir_req  in  2  requested direction: UP=00, DOWN=01, RIGHT=10, LEFT=11
- food_x / food_y  in  XW / YW  food cell
- game_state  out  2  RUNNING=00, DIE=01, INITIAL=10
- cur_dir  out  2  direction of the last executed move
- snake_len  out  LW  valid segment count
- snake_x_flat / snake_y_flat  out  MAX_LEN*XW / MAX_LEN*YW  segment i at [i*XW +: XW]; segment 0 is the head
- get_food  out  1  one-cycle pulse, head entered food cell
- hit_boundary / hit_self  out  1  death cause, held until start/reset

## Operation
- Reset and start both load the initial body: head (GRID_W/2, GRID_H/2), segment i at (GRID_W/2 − i, GRID_H/2) for i < INIT_LEN; segments ≥ INIT_LEN = (0,0); snake_len = INIT_LEN; cur_dir = pend_dir = RIGHT; flags 0.
- After reset, state = INITIAL. After start, state = RUNNING.
- Pending direction: each cycle, dir_req is latched into pend_dir unless it is the reverse of cur_dir. A reversal is ignored.
- A move occurs when state = RUNNING, step = 1, pause = 0 and start = 0.
- Next head = segment 0 moved one cell in pend_dir. UP decrements y; RIGHT increments x.
- WRAP=0: leaving [0,GRID_W−1]×[0,GRID_H−1] sets DIE and hit_boundary.
- WRAP=1: x = −1 wraps to GRID_W−1 and GRID_W wraps to 0; y wraps the same way. Non-power-of-2 bounds are compared explicitly, not by truncation.
- grow = (next head == food).
- Self hit: next head matches any segment i < snake_len − 1 (the tail cell is vacated). When grow = 1, the check covers i < snake_len.
- On a self hit: DIE, hit_self = 1.
- On death, body, length and cur_dir are frozen, and get_food is not pulsed.
- On a legal move, segments shift (seg[i] ← seg[i−1]), seg[0] ← next head, and cur_dir ← pend_dir.
- If grow: get_food pulses and snake_len increments, saturating at MAX_LEN. At saturation the snake moves without growing, but get_food still pulses.
- Both walls and self hit in the same move: hit_boundary only.
- start has priority over step in any state. pause does not block start.
- Outputs for segments ≥ snake_len are don't-care to consumers.

## Timing
- All state is registered. Move latency is 1: a step at edge t gives updated body, length, state and flags after edge t. get_food is high exactly for cycle t+1.
- A dir_req applied at edge t can steer a step at edge t+1 or later.
- Two steps on consecutive cycles perform two moves.
- Reset asserted mid-move dominates asynchronously. All outputs return to their initial-body values and state INITIAL.

## Structure
- snake_pkg: direction codes, state codes, and an opposite-direction function.
- Sub-module snake_next_head: combinational next-head computation plus the wrap/boundary decision, parametrised by GRID_W, GRID_H and WRAP.
- Main block contents:
  - pend_dir register
  - body shift registers
  - MAX_LEN-way comparator with length mask
  - 3-state FSM

## Test plan
- Reset, start, 5 steps with dir_req=RIGHT: head (16,12) → (21,12), len 3, no flags, state 00.
- Food at (17,12), one step: get_food pulses for 1 cycle, len 4, tail cell retained at (14,12).
- WRAP=0, head (31,y), step RIGHT → state 01, hit_boundary=1, body unchanged. WRAP=1, same move → head (0,y), RUNNING.
- Length 5 snake turned UP, LEFT, DOWN into its own body → hit_self=1. Tail-chasing into the vacated tail cell without food → no death.
- dir_req=LEFT while cur_dir=RIGHT → ignored, head keeps moving RIGHT. pause=1 with step → no move. Reaching MAX_LEN and eating again → len stays MAX_LEN, get_food pulses.
- Async rst pulse between steps and start asserted in DIE → initial body restored, correct state (INITIAL / RUNNING), flags cleared.
